// File: rtl/comparator_bist_pkg.sv
// Shared types for the comparator self-test engine: FSM states and the golden a>b reference.
package comparator_bist_pkg;

   typedef enum logic [1:0] {IDLE, HOLD, CHECK, DONE} state_t;

   localparam int MAX_WIDTH = 8;

   function automatic logic gt_golden(input logic [MAX_WIDTH-1:0] a, input logic [MAX_WIDTH-1:0] b);
      return a > b;
   endfunction

endpackage

// File: rtl/comparator_bist_operand_sweeper.sv
// Operand vector counter: A is the upper half, B the lower half, so B sweeps fastest.
module operand_sweeper #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] vec_a,
   output logic [WIDTH-1:0] vec_b,
   output logic             last
);

   localparam int CW = 2 * WIDTH;

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign vec_a = cnt_q[CW-1:WIDTH];
   assign vec_b = cnt_q[WIDTH-1:0];
   assign last  = &cnt_q;

endmodule

// File: rtl/comparator_bist.sv
// Exhaustive self-test of a greater-than comparator: sweeps all (A,B) pairs, holds each
// SETTLE cycles, checks dut_gt against a>b, counts mismatches and captures the first one.
module comparator_bist
   import comparator_bist_pkg::*;
#(
   parameter int WIDTH  = 2,
   parameter int SETTLE = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic [WIDTH-1:0]   dut_a,
   output logic [WIDTH-1:0]   dut_b,
   input  logic               dut_gt,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [2*WIDTH:0]   err_count,
   output logic               fail_valid,
   output logic [WIDTH-1:0]   first_fail_a,
   output logic [WIDTH-1:0]   first_fail_b
);

   localparam int EW = 2 * WIDTH + 1;
   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   // With no settle time every vector is checked on the cycle it appears.
   localparam state_t VEC_STATE = (SETTLE == 0) ? CHECK : HOLD;

   state_t          state_q, state_d;
   logic [SW-1:0]   settle_q, settle_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            pass_q, pass_d;
   logic [EW-1:0]   err_q, err_d;
   logic            fv_q, fv_d;
   logic [WIDTH-1:0] ffa_q, ffa_d;
   logic [WIDTH-1:0] ffb_q, ffb_d;
   logic            sweep_clr, sweep_en, sweep_last, mismatch;

   operand_sweeper #(.WIDTH(WIDTH)) u_sweeper (
      .clk   (clk),
      .rst   (rst),
      .clr   (sweep_clr),
      .en    (sweep_en),
      .vec_a (dut_a),
      .vec_b (dut_b),
      .last  (sweep_last)
   );

   always_comb begin
      state_d   = state_q;
      settle_d  = settle_q;
      busy_d    = busy_q;
      done_d    = done_q;
      pass_d    = pass_q;
      err_d     = err_q;
      fv_d      = fv_q;
      ffa_d     = ffa_q;
      ffb_d     = ffb_q;
      sweep_clr = 1'b0;
      sweep_en  = 1'b0;
      mismatch  = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d   = VEC_STATE;
               sweep_clr = 1'b1;
               settle_d  = '0;
               busy_d    = 1'b1;
               done_d    = 1'b0;
               pass_d    = 1'b0;
               err_d     = '0;
               fv_d      = 1'b0;
               ffa_d     = '0;
               ffb_d     = '0;
            end
         end
         HOLD: begin
            if (int'(settle_q) >= SETTLE - 1) begin
               state_d = CHECK;
            end else begin
               settle_d = settle_q + SW'(1);
            end
         end
         CHECK: begin
            mismatch = (dut_gt != gt_golden(MAX_WIDTH'(dut_a), MAX_WIDTH'(dut_b)));
            if (mismatch) begin
               err_d = err_q + EW'(1);
               if (!fv_q) begin
                  fv_d  = 1'b1;
                  ffa_d = dut_a;
                  ffb_d = dut_b;
               end
            end
            if (sweep_last) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_d == '0);
            end else begin
               sweep_en = 1'b1;
               settle_d = '0;
               state_d  = VEC_STATE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         settle_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         err_q    <= '0;
         fv_q     <= 1'b0;
         ffa_q    <= '0;
         ffb_q    <= '0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
         err_q    <= err_d;
         fv_q     <= fv_d;
         ffa_q    <= ffa_d;
         ffb_q    <= ffb_d;
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign pass         = pass_q;
   assign err_count    = err_q;
   assign fail_valid   = fv_q;
   assign first_fail_a = ffa_q;
   assign first_fail_b = ffb_q;

endmodule

// File: tb/tb_comparator_bist.sv
// Bench for comparator_bist: two instances (SETTLE=1 and SETTLE=0) driving a faultable comparator.
module tb_comparator_bist;

   localparam int W = 2;
   localparam int N = 16;

   typedef struct packed {
      logic [1:0] a;
      logic [1:0] b;
      logic       busy;
      logic       done;
      logic       pass;
      logic [4:0] err;
      logic       fv;
      logic [1:0] ffa;
      logic [1:0] ffb;
   } obs_t;

   typedef struct {
      int inst;
      int mode;
      int exp_err;
      int exp_fv;
      int exp_fa;
      int exp_fb;
      int exp_pass;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst0 = 1'b1, rst1 = 1'b1, start0 = 1'b0, start1 = 1'b0;
   logic [1:0] a0, b0, a1, b1, ffa0, ffb0, ffa1, ffb1;
   logic busy0, done0, pass0, fv0, busy1, done1, pass1, fv1;
   logic [4:0] err0, err1;
   logic gt0, gt1;
   logic [1:0]  mode = 2'd0;
   logic [15:0] mask = 16'd0;
   obs_t o0, o1;

   int n_chk = 0;
   int n_pass = 0;

   // Comparator under test: 0 correct, 1 stuck-at-0, 2 inverted, 3 random per-vector flips.
   function automatic logic fgt(input logic [1:0] m, input logic [15:0] mk,
                                input logic [1:0] a, input logic [1:0] b);
      logic g;
      int   idx;
      g   = (a > b);
      idx = int'(a) * 4 + int'(b);
      case (m)
         2'd0:    return g;
         2'd1:    return 1'b0;
         2'd2:    return !g;
         default: return g ^ mk[idx];
      endcase
   endfunction

   always_comb begin
      gt0 = fgt(mode, mask, a0, b0);
      gt1 = fgt(mode, mask, a1, b1);
   end

   comparator_bist #(.WIDTH(W), .SETTLE(1)) u_dut0 (
      .clk(clk), .rst(rst0), .start(start0), .dut_a(a0), .dut_b(b0), .dut_gt(gt0),
      .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_valid(fv0),
      .first_fail_a(ffa0), .first_fail_b(ffb0)
   );

   comparator_bist #(.WIDTH(W), .SETTLE(0)) u_dut1 (
      .clk(clk), .rst(rst1), .start(start1), .dut_a(a1), .dut_b(b1), .dut_gt(gt1),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_valid(fv1),
      .first_fail_a(ffa1), .first_fail_b(ffb1)
   );

   assign o0 = '{a: a0, b: b0, busy: busy0, done: done0, pass: pass0, err: err0,
                 fv: fv0, ffa: ffa0, ffb: ffb0};
   assign o1 = '{a: a1, b: b1, busy: busy1, done: done1, pass: pass1, err: err1,
                 fv: fv1, ffa: ffa1, ffb: ffb1};

   function automatic obs_t pick(input int s);
      return (s == 0) ? o0 : o1;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic set_start(input int s, input logic v);
      if (s == 0) start0 = v;
      else        start1 = v;
   endtask

   // Reference: walk every (a,b) pair in sweep order and tally what the comparator gets wrong.
   task automatic model(input logic [1:0] m, input logic [15:0] mk, output int err,
                        output int fv, output int fa, output int fb);
      err = 0; fv = 0; fa = 0; fb = 0;
      for (int a = 0; a < 4; a++) begin
         for (int b = 0; b < 4; b++) begin
            if (fgt(m, mk, 2'(a), 2'(b)) != (a > b)) begin
               err++;
               if (fv == 0) begin
                  fv = 1; fa = a; fb = b;
               end
            end
         end
      end
   endtask

   task automatic run_sweep(input string tag, input int s, input int restart_at,
                            input int e_err, input int e_fv, input int e_fa,
                            input int e_fb, input int e_pass);
      int   st, len, v;
      bit   seq_ok;
      obs_t o;
      st  = (s == 0) ? 1 : 0;
      len = N * (st + 1);
      @(negedge clk);
      set_start(s, 1'b1);
      @(posedge clk);
      @(negedge clk);
      set_start(s, 1'b0);
      seq_ok = 1'b1;
      for (int k = 0; k < len; k++) begin
         o = pick(s);
         v = k / (st + 1);
         if (o.a != 2'(v / 4) || o.b != 2'(v % 4) || !o.busy || o.done) seq_ok = 1'b0;
         if (k == 0)
            chk({tag, "_start_clear"}, int'({o.err, o.fv, o.done, o.pass}), 0);
         set_start(s, (k == restart_at) ? 1'b1 : 1'b0);
         @(negedge clk);
      end
      set_start(s, 1'b0);
      o = pick(s);
      chk({tag, "_operand_seq"}, int'(seq_ok), 1);
      chk({tag, "_done_timing"}, int'({o.done, o.busy}), 2);
      chk({tag, "_held_last"}, int'({o.a, o.b}), 15);
      chk({tag, "_err_count"}, int'(o.err), e_err);
      chk({tag, "_fail_valid"}, int'(o.fv), e_fv);
      chk({tag, "_first_fail"}, int'({o.ffa, o.ffb}), e_fa * 4 + e_fb);
      chk({tag, "_pass"}, int'(o.pass), e_pass);
      @(negedge clk);
      o = pick(s);
      chk({tag, "_done_held"}, int'({o.done, o.busy, o.pass}), 4 + e_pass);
   endtask

   vec_t tbl[4];

   initial begin
      int e_err, e_fv, e_fa, e_fb, wait_cnt;
      tbl[0] = '{inst: 0, mode: 0, exp_err: 0,  exp_fv: 0, exp_fa: 0, exp_fb: 0, exp_pass: 1};
      tbl[1] = '{inst: 0, mode: 1, exp_err: 6,  exp_fv: 1, exp_fa: 1, exp_fb: 0, exp_pass: 0};
      tbl[2] = '{inst: 0, mode: 2, exp_err: 16, exp_fv: 1, exp_fa: 0, exp_fb: 0, exp_pass: 0};
      tbl[3] = '{inst: 1, mode: 0, exp_err: 0,  exp_fv: 0, exp_fa: 0, exp_fb: 0, exp_pass: 1};

      repeat (3) @(negedge clk);
      chk("reset_inst0", int'(o0), 0);
      chk("reset_inst1", int'(o1), 0);

      // rst wins over a simultaneous start
      start0 = 1'b1;
      @(negedge clk);
      chk("rst_beats_start", int'(o0), 0);
      start0 = 1'b0;
      rst0 = 1'b0;
      rst1 = 1'b0;
      @(negedge clk);
      chk("idle_after_reset", int'({busy0, done0}), 0);

      // Table sweeps; rows 1->2 also exercise restart after DONE clearing a failing result.
      foreach (tbl[i]) begin
         mode = 2'(tbl[i].mode);
         run_sweep($sformatf("tbl%0d", i), tbl[i].inst, -1, tbl[i].exp_err, tbl[i].exp_fv,
                   tbl[i].exp_fa, tbl[i].exp_fb, tbl[i].exp_pass);
      end

      // start re-pulsed mid-sweep must not disturb the sweep
      mode = 2'd1;
      run_sweep("restart_mid", 0, 10, 6, 1, 1, 0, 0);

      // Randomized faulty comparators against the reference model
      for (int r = 0; r < 6; r++) begin
         mode = 2'd3;
         mask = 16'($urandom);
         if (r == 0) mask = 16'h8000;
         model(mode, mask, e_err, e_fv, e_fa, e_fb);
         run_sweep($sformatf("rand%0d", r), r % 2, -1, e_err, e_fv, e_fa, e_fb,
                   (e_err == 0) ? 1 : 0);
      end

      // Reset mid-sweep when dut_a reaches 2
      mode = 2'd1;
      @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      wait_cnt = 0;
      while (a0 != 2'd2 && wait_cnt < 100) begin
         @(negedge clk);
         wait_cnt++;
      end
      chk("reach_a2", int'(a0), 2);
      chk("mid_busy", int'(busy0), 1);
      rst0 = 1'b1;
      @(negedge clk);
      chk("mid_reset_clear", int'(o0), 0);
      rst0 = 1'b0;
      @(negedge clk);
      chk("idle_after_mid_reset", int'(o0), 0);
      mode = 2'd0;
      run_sweep("after_reset", 0, -1, 0, 0, 0, 0, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
